// File: rtl/spectrum_pkg.sv
// Shared widths, frame-length limits and the capture FSM state type for the
// spectrum capture path.
package spectrum_pkg;

  localparam int unsigned ADC_WIDTH       = 12;
  localparam int unsigned LOG2N_MIN       = 6;
  localparam int unsigned LOG2N_MAX       = 10;
  localparam int unsigned GAP_WIDTH       = 16;
  localparam int unsigned FRAME_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2,
    ST_DRAIN  = 2'd3
  } capture_state_t;

  // Limit a requested frame exponent to LOG2N_MIN..max_exp.
  function automatic logic [3:0] clamp_log2n(input logic [3:0] req, input int unsigned max_exp);
    logic [3:0] res;
    res = req;
    if (32'(req) < LOG2N_MIN) begin
      res = 4'(LOG2N_MIN);
    end else if (32'(req) > max_exp) begin
      res = 4'(max_exp);
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing a single asynchronous level into clk_sys.
module sync_2ff (
  input  logic clk_sys,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/capture_scheduler.sv
// Frames ADC samples from a FIFO into fixed-length FFT frames, with optional
// repeated capture separated by a run of discarded samples.
module capture_scheduler #(
  parameter int unsigned ADC_WIDTH = spectrum_pkg::ADC_WIDTH,
  parameter int unsigned LOG2N_MAX = spectrum_pkg::LOG2N_MAX,
  parameter int unsigned GAP_WIDTH = spectrum_pkg::GAP_WIDTH
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [3:0]           cfg_log2n,
  input  logic                 cfg_continuous,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic [ADC_WIDTH-1:0] fifo_sample,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  output logic                 fifo_read_enable,
  output logic [ADC_WIDTH-1:0] fft_data,
  output logic                 fft_valid,
  input  logic                 fft_ready,
  output logic                 fft_sof,
  output logic                 fft_eof,
  output logic                 busy,
  output logic                 overflow,
  output logic [15:0]          frame_count
);

  import spectrum_pkg::*;

  capture_state_t         state_q;
  logic [3:0]             log2n_q;
  logic                   cont_q;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic                   stop_pend_q;
  logic [LOG2N_MAX-1:0]   samp_cnt_q;
  logic [GAP_WIDTH-1:0]   gap_cnt_q;
  logic [ADC_WIDTH-1:0]   fft_data_q;
  logic                   fft_valid_q;
  logic                   fft_sof_q;
  logic                   fft_eof_q;
  logic                   overflow_q;
  logic [15:0]            frame_count_q;

  logic                   full_sync;
  logic                   rd_en_c;
  logic                   accept;
  logic [LOG2N_MAX-1:0]   last_idx;
  logic                   is_last;

  sync_2ff u_full_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .d_i     (fifo_full),
    .q_o     (full_sync)
  );

  assign accept   = fft_valid_q && fft_ready;
  assign last_idx = LOG2N_MAX'((32'd1 << log2n_q) - 32'd1);
  assign is_last  = (samp_cnt_q == last_idx);

  // Pop request: STREAM refills the output register, GAP discards freely.
  always_comb begin
    rd_en_c = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_STREAM: rd_en_c = !fifo_empty && (!fft_valid_q || fft_ready);
        ST_GAP:    rd_en_c = !fifo_empty;
        default:   rd_en_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      log2n_q       <= 4'(LOG2N_MIN);
      cont_q        <= 1'b0;
      gap_q         <= '0;
      stop_pend_q   <= 1'b0;
      samp_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      fft_data_q    <= '0;
      fft_valid_q   <= 1'b0;
      fft_sof_q     <= 1'b0;
      fft_eof_q     <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (accept) begin
        fft_valid_q <= 1'b0;
        fft_sof_q   <= 1'b0;
        fft_eof_q   <= 1'b0;
        if (fft_eof_q) begin
          frame_count_q <= frame_count_q + 16'd1;
        end
      end

      if (full_sync && (state_q == ST_STREAM || state_q == ST_GAP)) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            log2n_q       <= clamp_log2n(cfg_log2n, LOG2N_MAX);
            cont_q        <= cfg_continuous;
            gap_q         <= cfg_gap;
            stop_pend_q   <= stop;
            samp_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
            state_q       <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (stop) begin
            stop_pend_q <= 1'b1;
          end
          if (rd_en_c) begin
            fft_data_q  <= fifo_sample;
            fft_valid_q <= 1'b1;
            fft_sof_q   <= (samp_cnt_q == '0);
            fft_eof_q   <= is_last;
            if (is_last) begin
              samp_cnt_q <= '0;
              gap_cnt_q  <= '0;
              // A stop arriving with the final pop still ends the run here.
              if (cont_q && !stop_pend_q && !stop) begin
                state_q <= (gap_q != '0) ? ST_GAP : ST_STREAM;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + LOG2N_MAX'(1);
            end
          end
        end

        ST_GAP: begin
          if (stop) begin
            state_q <= ST_DRAIN;
          end else if (rd_en_c) begin
            if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
              gap_cnt_q <= '0;
              state_q   <= ST_STREAM;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_WIDTH'(1);
            end
          end
        end

        ST_DRAIN: begin
          stop_pend_q <= 1'b0;
          if (!fft_valid_q || accept) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_read_enable = rd_en_c;
  assign fft_data         = fft_data_q;
  assign fft_valid        = fft_valid_q;
  assign fft_sof          = fft_sof_q;
  assign fft_eof          = fft_eof_q;
  assign busy             = (state_q != ST_IDLE);
  assign overflow         = overflow_q;
  assign frame_count      = frame_count_q;

endmodule
